ysyx_22050133_aclint: RTL and testbench

YSYX_22050133_ACLINT -- requirements
Module: ysyx_22050133_aclint

---
 rtl/ysyx_22050133_aclint.sv | 249 ++++++++++++++++++++++++
 tb/tb_ysyx_22050133_aclint.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22050133_aclint.sv
// ACLINT timer/software-interrupt block with a single-beat AXI-style slave port.
// Register map (offsets from BASE): msip[h] 0x0000+4h, mtimecmp[h] 0x4000+8h, mtime 0xBFF8.
module ysyx_22050133_aclint #(
  parameter int unsigned NHART    = 2,
  parameter int unsigned TICK_DIV = 4,
  parameter logic [31:0] BASE     = 32'h0200_0000
) (
  input  logic              clk,
  input  logic              rst,
  output logic [NHART-1:0]  mtip,
  output logic [NHART-1:0]  msip,
  input  logic              axi_aw_valid_i,
  output logic              axi_aw_ready_o,
  input  logic [31:0]       axi_aw_addr_i,
  input  logic              axi_w_valid_i,
  output logic              axi_w_ready_o,
  input  logic [63:0]       axi_w_data_i,
  input  logic [7:0]        axi_w_strb_i,
  output logic              axi_b_valid_o,
  input  logic              axi_b_ready_i,
  output logic [1:0]        axi_b_resp_o,
  input  logic              axi_ar_valid_i,
  output logic              axi_ar_ready_o,
  input  logic [31:0]       axi_ar_addr_i,
  output logic              axi_r_valid_o,
  input  logic              axi_r_ready_i,
  output logic [63:0]       axi_r_data_o,
  output logic [1:0]        axi_r_resp_o
);

  localparam int unsigned  HW          = (NHART > 1) ? $clog2(NHART) : 1;
  localparam int unsigned  CW          = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX    = CW'(TICK_DIV - 1);
  localparam logic [15:0]  BASE_LO     = BASE[15:0];
  localparam logic [1:0]   RESP_OKAY   = 2'b00;
  localparam logic [1:0]   RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {W_ADDR, W_DATA, W_RESP} w_state_e;
  typedef enum logic       {R_ADDR, R_DATA}         r_state_e;
  typedef enum logic [1:0] {T_NONE, T_MSIP, T_CMP, T_TIME} tgt_e;

  typedef struct packed {
    tgt_e          tgt;
    logic [HW-1:0] idx;
    logic          hi;   // msip word sits in the upper 32-bit lane
  } dec_t;

  // Map a 16-bit region offset to a register target and hart index.
  function automatic dec_t decode(input logic [15:0] off);
    dec_t        d;
    logic [15:0] cmp_off;
    d.tgt   = T_NONE;
    d.idx   = '0;
    d.hi    = off[2];
    cmp_off = off - 16'h4000;
    if (off == 16'hBFF8) begin
      d.tgt = T_TIME;
    end else if (off < 16'h4000) begin
      if (off[1:0] == 2'b00 && 32'(off[15:2]) < NHART) begin
        d.tgt = T_MSIP;
        d.idx = HW'(off[15:2]);
      end
    end else if (cmp_off[2:0] == 3'b000 && 32'(cmp_off[15:3]) < NHART) begin
      d.tgt = T_CMP;
      d.idx = HW'(cmp_off[15:3]);
    end
    return d;
  endfunction

  // Byte-strobed merge of write data into an existing 64-bit value.
  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] data,
                                        input logic [7:0] strb);
    logic [63:0] m;
    m = old;
    for (int b = 0; b < 8; b++) begin
      if (strb[b]) m[8*b +: 8] = data[8*b +: 8];
    end
    return m;
  endfunction

  w_state_e          w_state_q, w_state_d;
  logic [15:0]       aw_off_q, aw_off_d;
  logic              aw_ready_q, w_ready_q, b_valid_q;
  logic [1:0]        b_resp_q, b_resp_d;
  logic              wr_en;
  dec_t              wdec;

  r_state_e          r_state_q, r_state_d;
  logic              ar_ready_q, r_valid_q;
  logic [63:0]       r_data_q, r_data_d;
  logic [1:0]        r_resp_q, r_resp_d;
  logic [15:0]       ar_off;
  dec_t              rdec;
  logic [63:0]       rd_val;

  logic [63:0]       mtime_q, mtime_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [63:0]       cmp_q [NHART];
  logic [63:0]       cmp_d [NHART];
  logic [NHART-1:0]  msip_q, msip_d, mtip_q, mtip_d;

  logic              unused_addr_hi;

  assign unused_addr_hi = ^{axi_aw_addr_i[31:16], axi_ar_addr_i[31:16]};
  assign wdec   = decode(aw_off_q);
  assign ar_off = axi_ar_addr_i[15:0] - BASE_LO;
  assign rdec   = decode(ar_off);

  // Write channel next state: address, then data (commit), then response.
  always_comb begin
    w_state_d = w_state_q;
    aw_off_d  = aw_off_q;
    b_resp_d  = b_resp_q;
    wr_en     = 1'b0;
    case (w_state_q)
      W_ADDR: if (axi_aw_valid_i) begin
        aw_off_d  = axi_aw_addr_i[15:0] - BASE_LO;
        w_state_d = W_DATA;
      end
      W_DATA: if (axi_w_valid_i) begin
        wr_en     = (wdec.tgt != T_NONE);
        b_resp_d  = (wdec.tgt == T_NONE) ? RESP_DECERR : RESP_OKAY;
        w_state_d = W_RESP;
      end
      W_RESP: if (axi_b_ready_i) w_state_d = W_ADDR;
      default: w_state_d = W_ADDR;
    endcase
  end

  // Read data mux over the current (pre-write) register contents.
  always_comb begin
    rd_val = '0;
    case (rdec.tgt)
      T_MSIP:  rd_val = rdec.hi ? {31'b0, msip_q[rdec.idx], 32'b0} : {63'b0, msip_q[rdec.idx]};
      T_CMP:   rd_val = cmp_q[rdec.idx];
      T_TIME:  rd_val = mtime_q;
      default: rd_val = '0;
    endcase
  end

  // Read channel next state: sample on AR handshake, hold until R handshake.
  always_comb begin
    r_state_d = r_state_q;
    r_data_d  = r_data_q;
    r_resp_d  = r_resp_q;
    case (r_state_q)
      R_ADDR: if (axi_ar_valid_i) begin
        r_data_d  = rd_val;
        r_resp_d  = (rdec.tgt == T_NONE) ? RESP_DECERR : RESP_OKAY;
        r_state_d = R_DATA;
      end
      R_DATA: if (axi_r_ready_i) r_state_d = R_ADDR;
      default: r_state_d = R_ADDR;
    endcase
  end

  // mtime prescaler; a software write to mtime wins over the tick and restarts the prescaler.
  always_comb begin
    mtime_d = mtime_q;
    cnt_d   = cnt_q;
    if (cnt_q == CNT_MAX) begin
      cnt_d   = '0;
      mtime_d = mtime_q + 64'd1;
    end else begin
      cnt_d   = cnt_q + CW'(1);
    end
    if (wr_en && wdec.tgt == T_TIME) begin
      mtime_d = merge(mtime_q, axi_w_data_i, axi_w_strb_i);
      cnt_d   = '0;
    end
  end

  // Per-hart msip/mtimecmp updates and timer compare.
  always_comb begin
    for (int unsigned h = 0; h < NHART; h++) begin
      msip_d[h] = msip_q[h];
      cmp_d[h]  = cmp_q[h];
      mtip_d[h] = (mtime_q >= cmp_q[h]);
      if (wr_en && wdec.idx == HW'(h)) begin
        if (wdec.tgt == T_MSIP) begin
          if (wdec.hi) begin
            if (axi_w_strb_i[4]) msip_d[h] = axi_w_data_i[32];
          end else begin
            if (axi_w_strb_i[0]) msip_d[h] = axi_w_data_i[0];
          end
        end
        if (wdec.tgt == T_CMP) cmp_d[h] = merge(cmp_q[h], axi_w_data_i, axi_w_strb_i);
      end
    end
  end

  // Bus FSM state and registered handshake/response outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state_q  <= W_ADDR;
      aw_off_q   <= '0;
      aw_ready_q <= 1'b1;
      w_ready_q  <= 1'b0;
      b_valid_q  <= 1'b0;
      b_resp_q   <= RESP_OKAY;
      r_state_q  <= R_ADDR;
      ar_ready_q <= 1'b1;
      r_valid_q  <= 1'b0;
      r_data_q   <= '0;
      r_resp_q   <= RESP_OKAY;
    end else begin
      w_state_q  <= w_state_d;
      aw_off_q   <= aw_off_d;
      aw_ready_q <= (w_state_d == W_ADDR);
      w_ready_q  <= (w_state_d == W_DATA);
      b_valid_q  <= (w_state_d == W_RESP);
      b_resp_q   <= b_resp_d;
      r_state_q  <= r_state_d;
      ar_ready_q <= (r_state_d == R_ADDR);
      r_valid_q  <= (r_state_d == R_DATA);
      r_data_q   <= r_data_d;
      r_resp_q   <= r_resp_d;
    end
  end

  // Timer, compare and interrupt registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mtime_q <= '0;
      cnt_q   <= '0;
      msip_q  <= '0;
      mtip_q  <= '0;
      for (int unsigned h = 0; h < NHART; h++) cmp_q[h] <= '1;
    end else begin
      mtime_q <= mtime_d;
      cnt_q   <= cnt_d;
      msip_q  <= msip_d;
      mtip_q  <= mtip_d;
      for (int unsigned h = 0; h < NHART; h++) cmp_q[h] <= cmp_d[h];
    end
  end

  assign mtip           = mtip_q;
  assign msip           = msip_q;
  assign axi_aw_ready_o = aw_ready_q;
  assign axi_w_ready_o  = w_ready_q;
  assign axi_b_valid_o  = b_valid_q;
  assign axi_b_resp_o   = b_resp_q;
  assign axi_ar_ready_o = ar_ready_q;
  assign axi_r_valid_o  = r_valid_q;
  assign axi_r_data_o   = r_data_q;
  assign axi_r_resp_o   = r_resp_q;

endmodule

// File: tb/tb_ysyx_22050133_aclint.sv
// Directed bench for ysyx_22050133_aclint (NHART=2, TICK_DIV=4).
module tb_ysyx_22050133_aclint;

  localparam int TD  = 4;
  localparam int TMO = 50;

  logic        clk;
  logic        rst;
  logic [1:0]  mtip, msip;
  logic        aw_valid, aw_ready;
  logic [31:0] aw_addr;
  logic        w_valid, w_ready;
  logic [63:0] w_data;
  logic [7:0]  w_strb;
  logic        b_valid, b_ready;
  logic [1:0]  b_resp;
  logic        ar_valid, ar_ready;
  logic [31:0] ar_addr;
  logic        r_valid, r_ready;
  logic [63:0] r_data;
  logic [1:0]  r_resp;

  int          n_chk;
  int          n_pass;
  int          cyc;
  logic [63:0] mbase;
  int          mcyc;

  ysyx_22050133_aclint #(.NHART(2), .TICK_DIV(TD), .BASE(32'h0200_0000)) dut (
    .clk            (clk),
    .rst            (rst),
    .mtip           (mtip),
    .msip           (msip),
    .axi_aw_valid_i (aw_valid),
    .axi_aw_ready_o (aw_ready),
    .axi_aw_addr_i  (aw_addr),
    .axi_w_valid_i  (w_valid),
    .axi_w_ready_o  (w_ready),
    .axi_w_data_i   (w_data),
    .axi_w_strb_i   (w_strb),
    .axi_b_valid_o  (b_valid),
    .axi_b_ready_i  (b_ready),
    .axi_b_resp_o   (b_resp),
    .axi_ar_valid_i (ar_valid),
    .axi_ar_ready_o (ar_ready),
    .axi_ar_addr_i  (ar_addr),
    .axi_r_valid_o  (r_valid),
    .axi_r_ready_i  (r_ready),
    .axi_r_data_o   (r_data),
    .axi_r_resp_o   (r_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Rising edges since reset release.
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  // mtime as seen by a read whose AR handshake is at rising edge q.
  function automatic logic [63:0] mt_exp(input int q);
    return mbase + 64'((q - 1 - mcyc) / TD);
  endfunction

  task automatic do_write(input logic [31:0] addr, input logic [63:0] data, input logic [7:0] strb,
                          input int b_delay, output logic [1:0] resp, output int w_cyc);
    int n;
    @(negedge clk);
    aw_addr = addr; aw_valid = 1'b1;
    n = 0;
    while (aw_ready !== 1'b1 && n < TMO) begin @(negedge clk); n++; end
    chk("aw_ready", aw_ready, 1);
    @(posedge clk); @(negedge clk);
    aw_valid = 1'b0; w_data = data; w_strb = strb; w_valid = 1'b1;
    n = 0;
    while (w_ready !== 1'b1 && n < TMO) begin @(negedge clk); n++; end
    chk("w_ready", w_ready, 1);
    @(posedge clk); @(negedge clk);
    w_cyc = cyc; w_valid = 1'b0;
    n = 0;
    while (b_valid !== 1'b1 && n < TMO) begin @(negedge clk); n++; end
    chk("b_valid", b_valid, 1);
    for (int i = 0; i < b_delay; i++) begin
      chk("b_hold", b_valid, 1);
      chk("aw_blocked", aw_ready, 0);
      @(negedge clk);
    end
    resp = b_resp; b_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    b_ready = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] addr, input int r_delay, output logic [63:0] data,
                         output logic [1:0] resp, output int hs_cyc);
    int n;
    @(negedge clk);
    ar_addr = addr; ar_valid = 1'b1;
    n = 0;
    while (ar_ready !== 1'b1 && n < TMO) begin @(negedge clk); n++; end
    chk("ar_ready", ar_ready, 1);
    @(posedge clk); @(negedge clk);
    hs_cyc = cyc; ar_valid = 1'b0;
    n = 0;
    while (r_valid !== 1'b1 && n < TMO) begin @(negedge clk); n++; end
    chk("r_valid", r_valid, 1);
    data = r_data; resp = r_resp;
    for (int i = 0; i < r_delay; i++) begin
      @(negedge clk);
      chk("r_hold_valid", r_valid, 1);
      chk("r_hold_data", r_data, data);
    end
    r_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    r_ready = 1'b0;
  endtask

  initial begin
    logic [63:0] d;
    logic [1:0]  rs;
    int          q, wc, n;
    n_chk = 0; n_pass = 0; mbase = '0; mcyc = 0;
    rst = 1'b1;
    aw_valid = 0; aw_addr = '0; w_valid = 0; w_data = '0; w_strb = '0; b_ready = 0;
    ar_valid = 0; ar_addr = '0; r_ready = 0;

    // Reset values.
    repeat (2) @(negedge clk);
    chk("rst_aw_ready", aw_ready, 1);
    chk("rst_ar_ready", ar_ready, 1);
    chk("rst_w_ready", w_ready, 0);
    chk("rst_b_valid", b_valid, 0);
    chk("rst_r_valid", r_valid, 0);
    chk("rst_r_data", r_data, 0);
    chk("rst_resps", {b_resp, r_resp}, 0);
    chk("rst_mtip", mtip, 0);
    chk("rst_msip", msip, 0);
    rst = 1'b0;

    // 40 idle cycles then read mtime: 40/4 = 10.
    repeat (40) @(posedge clk);
    do_read(32'h0200_BFF8, 0, d, rs, q);
    chk("idle_hs_cycle", q, 41);
    chk("idle_mtime", d, 64'd10);
    chk("idle_mtime_resp", rs, 2'b00);
    chk("idle_mtip", mtip, 0);

    // mtimecmp[1]=20: mtime reaches 20 at edge 80, mtip[1] registered at edge 81.
    do_write(32'h0200_4008, 64'd20, 8'hFF, 0, rs, wc);
    chk("cmp1_resp", rs, 2'b00);
    chk("mtip1_early", mtip[1], 0);
    n = 0;
    while (mtip[1] !== 1'b1 && n < 300) begin @(negedge clk); n++; end
    chk("mtip1_rise", mtip[1], 1);
    chk("mtip1_cycle", cyc, 81);
    chk("mtip0_low", mtip[0], 0);

    // msip lanes.
    do_write(32'h0200_0004, 64'h1_0000_0000, 8'hF0, 0, rs, wc);
    chk("msip1_resp", rs, 2'b00);
    chk("msip_after_h1", msip, 2'b10);
    do_write(32'h0200_0000, 64'd1, 8'h0F, 0, rs, wc);
    chk("msip_after_h0", msip, 2'b11);
    do_write(32'h0200_0000, 64'd0, 8'h00, 0, rs, wc);
    chk("msip_zero_strb", msip, 2'b11);
    do_read(32'h0200_0004, 0, d, rs, q);
    chk("msip1_read", d, 64'h1_0000_0000);
    do_read(32'h0200_0000, 2, d, rs, q);
    chk("msip0_read", d, 64'h1);
    chk("msip0_read_resp", rs, 2'b00);

    // Single byte strobe into mtimecmp[0].
    do_write(32'h0200_4000, 64'h1234_5678_9ABC_DEF0, 8'h01, 0, rs, wc);
    do_read(32'h0200_4000, 0, d, rs, q);
    chk("cmp0_partial", d, 64'hFFFF_FFFF_FFFF_FFF0);
    do_read(32'h0200_4008, 0, d, rs, q);
    chk("cmp1_read", d, 64'd20);

    // Decode errors.
    do_read(32'h0200_8000, 0, d, rs, q);
    chk("unmapped_resp", rs, 2'b11);
    chk("unmapped_data", d, 64'd0);
    do_read(32'h0200_4010, 0, d, rs, q);
    chk("cmp2_resp", rs, 2'b11);
    do_read(32'h0200_0008, 0, d, rs, q);
    chk("msip2_resp", rs, 2'b11);
    chk("msip2_data", d, 64'd0);
    do_write(32'h0200_8000, 64'hDEAD, 8'hFF, 5, rs, wc);
    chk("unmapped_wr_resp", rs, 2'b11);

    // mtime read with r_ready stalled.
    do_read(32'h0200_BFF8, 3, d, rs, q);
    chk("mtime_stalled", d, mt_exp(q));

    // mtime wrap: written value holds for TICK_DIV edges, then wraps to 0.
    do_write(32'h0200_BFF8, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 0, rs, wc);
    mbase = 64'hFFFF_FFFF_FFFF_FFFF; mcyc = wc;
    chk("mtime_wr_resp", rs, 2'b00);
    do_read(32'h0200_BFF8, 0, d, rs, q);
    chk("mtime_pre_wrap", d, mt_exp(q));
    chk("mtime_pre_wrap_lit", d, 64'hFFFF_FFFF_FFFF_FFFF);
    repeat (2) @(negedge clk);
    do_read(32'h0200_BFF8, 0, d, rs, q);
    chk("mtime_wrapped", d, mt_exp(q));
    chk("mtime_wrapped_lit", d, 64'd0);

    // Reset while the write to mtimecmp[0] sits in W_DATA.
    @(negedge clk);
    aw_addr = 32'h0200_4000; aw_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    aw_valid = 1'b0; w_data = 64'd0; w_strb = 8'hFF; w_valid = 1'b1;
    chk("mid_w_ready", w_ready, 1);
    #2 rst = 1'b1;
    #1;
    chk("async_aw_ready", aw_ready, 1);
    chk("async_w_ready", w_ready, 0);
    chk("async_b_valid", b_valid, 0);
    chk("async_msip", msip, 0);
    chk("async_mtip", mtip, 0);
    chk("async_r_data", r_data, 0);
    w_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0; mbase = '0; mcyc = 0;
    do_read(32'h0200_4000, 0, d, rs, q);
    chk("cmp0_after_rst", d, 64'hFFFF_FFFF_FFFF_FFFF);
    do_read(32'h0200_BFF8, 0, d, rs, q);
    chk("mtime_after_rst", d, mt_exp(q));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
